// File: rtl/uart_rx_core_if.sv
// rtl/uart_rx_core_if.sv - serial line and received-byte bundle for uart_rx_core
`timescale 1ns/1ps
interface uart_rx_core_if;
    logic       rx;
    logic       ready;
    logic [7:0] data;

    modport master (output rx, input ready, input data);
    modport slave  (input rx, output ready, output data);
endinterface

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 UART receiver with mid-bit sampling
`timescale 1ns/1ps
module uart_rx_core #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 115_200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_core_if.slave bus
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          ready_q, ready_d;
    logic          rx_meta_q, rx_meta_d;
    logic          rx_s_q, rx_s_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        ready_d   = 1'b0;
        rx_meta_d = bus.rx;
        rx_s_d    = rx_meta_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    // A start bit that is gone by mid-bit was only a glitch.
                    if (!rx_s_q) begin
                        bit_idx_d = 3'd0;
                        state_d   = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    // Leave at mid stop bit so an early next start edge is not missed.
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        ready_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            ready_q   <= 1'b0;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.data  = data_q;
endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed and randomized frames against a frame-level receiver model
`timescale 1ns/1ps
module tb_uart_rx_core;
    localparam int  CLK_FREQ = 100_000_000;
    localparam int  BAUD     = 1_152_000;
    localparam int  CPB      = CLK_FREQ / BAUD;
    localparam int  HALF     = CPB / 2;
    localparam real BIT_NS   = 1.0e9 / BAUD;
    localparam int  LAT_NOM  = 2 + HALF + 9 * CPB;

    logic clk;
    logic rst;
    uart_rx_core_if bus();

    uart_rx_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         pulses = 0;
    int         width_err = 0;
    int         data_glitch = 0;
    int         start_cyc = 0;
    int         pulse_cyc = 0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data = 8'h00;

    // Frame-level model: a good stop bit yields one pulse and the new byte.
    int         exp_pulses = 0;
    logic [7:0] exp_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.ready === 1'b1) begin
            pulses    <= pulses + 1;
            pulse_cyc <= cyc;
            if (prev_ready === 1'b1) width_err <= width_err + 1;
        end
        if (rst && bus.ready !== 1'b1 && bus.data !== prev_data) data_glitch <= data_glitch + 1;
        prev_ready <= bus.ready;
        prev_data  <= bus.data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input real bit_ns, input real stop_ns);
        start_cyc = cyc;
        bus.rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            #(bit_ns);
        end
        bus.rx = stop;
        #(stop_ns);
        bus.rx = 1'b1;
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop);
        if (stop) begin
            exp_pulses++;
            exp_data = b;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_pulses"}, pulses, exp_pulses);
        check({tag, "_data"}, bus.data, exp_data);
    endtask

    initial begin
        int lat;
        bus.rx = 1'b1;
        rst    = 1'b0;
        #50;
        check("reset_ready", bus.ready, 1'b0);
        check("reset_data", bus.data, 8'h00);
        #50 rst = 1'b1;

        #(3 * BIT_NS);
        check("idle_ready", bus.ready, 1'b0);
        check_state("idle");

        #(150 - 100 - 3 * BIT_NS + 3 * BIT_NS);
        send_frame(8'hD5, 1'b1, BIT_NS, BIT_NS);
        model_frame(8'hD5, 1'b1);
        #(BIT_NS);
        check_state("frame1");
        lat = pulse_cyc - start_cyc;
        checks++;
        assert (lat >= LAT_NOM - 1 && lat <= LAT_NOM + 2) else begin
            errors++;
            $error("FAIL latency observed=%0d expected=%0d..%0d", lat, LAT_NOM - 1, LAT_NOM + 2);
        end

        send_frame(8'hD5, 1'b1, BIT_NS, 0.92 * BIT_NS);
        model_frame(8'hD5, 1'b1);
        send_frame(8'hD5, 1'b1, BIT_NS, BIT_NS);
        model_frame(8'hD5, 1'b1);
        #(BIT_NS);
        check_state("back_to_back");

        bus.rx = 1'b0;
        #200;
        bus.rx = 1'b1;
        #(2 * BIT_NS);
        check_state("glitch");
        send_frame(8'h3C, 1'b1, BIT_NS, BIT_NS);
        model_frame(8'h3C, 1'b1);
        #(BIT_NS);
        check_state("after_glitch");

        send_frame(8'hA5, 1'b0, BIT_NS, BIT_NS);
        model_frame(8'hA5, 1'b0);
        #(2 * BIT_NS);
        check_state("framing_err");
        send_frame(8'h5A, 1'b1, BIT_NS, BIT_NS);
        model_frame(8'h5A, 1'b1);
        #(BIT_NS);
        check_state("after_ferr");

        fork
            send_frame(8'h96, 1'b1, BIT_NS, BIT_NS);
            begin
                #(5.5 * BIT_NS);
                rst = 1'b0;
                #2;
                check("midreset_ready", bus.ready, 1'b0);
                check("midreset_data", bus.data, 8'h00);
            end
        join
        exp_data = 8'h00;
        #(BIT_NS);
        rst = 1'b1;
        #(BIT_NS);
        check_state("after_reset");
        send_frame(8'hFF, 1'b1, BIT_NS, BIT_NS);
        model_frame(8'hFF, 1'b1);
        #(BIT_NS);
        check_state("ff_frame");

        bus.rx = 1'b0;
        #(12 * BIT_NS);
        bus.rx = 1'b1;
        #(2 * BIT_NS);
        check_state("break");

        for (int k = 0; k < 8; k++) begin
            logic [7:0] b;
            logic       stop;
            int         r;
            real        bn;
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            r    = int'($urandom_range(0, 30));
            bn   = BIT_NS * (1.0 + (r - 15) / 1000.0);
            send_frame(b, stop, bn, bn);
            model_frame(b, stop);
            #($urandom_range(100, 2000));
            #(BIT_NS);
            check_state("random");
        end

        check("pulse_width", width_err, 0);
        check("data_stable", data_glitch, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
